ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-select logic that directly feeds the ALU inputs SrcA, SrcB and Operation.
- Registers decoded ID-stage fields each cycle and inserts bubbles on flush or load-use hazard.
- Resolves RAW hazards by forwarding from MEM and WB, then selects PC/immediate versus register operands.
- Also drives store data and a combinational load-use stall request back to IF/ID.

Parameters:
DATA_WIDTH, 32, operand/PC/immediate width
OPCODE_LENGTH, 4, ALU operation code width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
stall  in  1  hold ID/EX contents (downstream not ready)
flush  in  1  squash ID/EX contents (branch taken)
id_valid  in  1  ID instruction valid
id_pc  in  DATA_WIDTH  ID PC
id_rs1_data  in  DATA_WIDTH  regfile read 1
id_rs2_data  in  DATA_WIDTH  regfile read 2
id_imm  in  DATA_WIDTH  sign-extended immediate
id_rs1_addr  in  REG_ADDR_W  source 1 index
id_rs2_addr  in  REG_ADDR_W  source 2 index
id_rd_addr  in  REG_ADDR_W  destination index
id_alu_src_a  in  1  1: SrcA=PC
id_alu_src_b  in  1  1: SrcB=imm
id_operation  in  OPCODE_LENGTH  ALU op code
id_reg_write  in  1  writes rd
id_mem_read  in  1  load
mem_rd_addr  in  REG_ADDR_W  EX/MEM destination
mem_reg_write  in  1  EX/MEM writes rd
mem_result  in  DATA_WIDTH  EX/MEM ALU result
wb_rd_addr  in  REG_ADDR_W  MEM/WB destination
wb_reg_write  in  1  MEM/WB writes rd
wb_result  in  DATA_WIDTH  MEM/WB writeback value
SrcA  out  DATA_WIDTH  ALU operand A
SrcB  out  DATA_WIDTH  ALU operand B
Operation  out  OPCODE_LENGTH  ALU op code
ex_valid  out  1  EX instruction valid
ex_rd_addr  out  REG_ADDR_W  EX destination
ex_reg_write  out  1  EX writes rd, gated by valid
ex_mem_read  out  1  EX is load, gated by valid
ex_store_data  out  DATA_WIDTH  forwarded rs2 value
load_use_hazard  out  1  combinational stall request to IF/ID

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port reset.
- Reset state: all ID/EX registers are 0, so ex_valid=0, Operation=0, ex_rd_addr=0, ex_reg_write=0 and ex_mem_read=0. SrcA, SrcB and ex_store_data read 0, because x0 is never forwarded.
- Register update priority on each rising clk: reset > flush > stall > load_use_hazard > capture.
  - flush: load a bubble. valid, reg_write and mem_read are 0; Operation, rd and rs addresses are 0; data fields are 0.
  - stall, without flush: hold every register.
  - load_use_hazard, without flush or stall: load a bubble.
  - Otherwise: capture all id_* fields. ex_reg_write and ex_mem_read are the captured values ANDed with id_valid.
- Hazard detection: load_use_hazard = ex_valid & ex_mem_read & (ex_rd_addr!=0) & id_valid & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr). It is combinational with zero latency. It is asserted even during stall; stall takes precedence for the register update.
- Forwarding is combinational from the registered rs1/rs2 indices. For operand A:
  - If mem_reg_write & mem_rd_addr!=0 & mem_rd_addr==ex_rs1, use mem_result.
  - Else if wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==ex_rs1, use wb_result.
  - Else use the registered rs1 data.
  - MEM has priority over WB when both match.
- Operand B uses the same forwarding rules with rs2. Index 0 is never forwarded.
- SrcA = ex_alu_src_a ? ex_pc : fwdA.
- SrcB = ex_alu_src_b ? ex_imm : fwdB.
- ex_store_data = fwdB always, independent of alu_src_b.
- Operation passes straight through from the register. The ALU treats op 0 on a bubble as a harmless AND.
- Latency: one cycle from ID inputs to registered outputs. Forwarding inputs reach SrcA/SrcB/ex_store_data in the same cycle.
- Data width: all data paths are DATA_WIDTH bits. There is no arithmetic in this block.
- Reset asserted mid-stall or mid-hazard: registers clear immediately, and load_use_hazard drops because ex_valid=0.
- flush and stall asserted in the same cycle: flush wins.
- flush and load_use_hazard asserted in the same cycle: bubble.

Test Plan:
- Reset, then capture:
  - Assert reset; check all outputs are 0.
  - Release; drive id_valid=1, id_rs1_data=5, id_rs2_data=7, id_operation=4'b0010, src_a=src_b=0, rd=3, no forwarding.
  - Next edge: SrcA=5, SrcB=7, Operation=0010, ex_rd_addr=3, ex_valid=1.
- MEM/WB forwarding priority:
  - EX holds rs1=4; mem_reg_write=1, mem_rd=4, mem_result=0x11; wb_reg_write=1, wb_rd=4, wb_result=0x22: SrcA=0x11.
  - Drop mem_reg_write: SrcA=0x22.
  - Set rs1=0 with mem_rd=0: SrcA equals the registered rs1 data (0).
- Immediate/PC select and store data:
  - alu_src_a=1, pc=0x100, alu_src_b=1, imm=0xFFFFFFFC, rs2=6, mem forwarding rd=6 with result 0x55.
  - Check SrcA=0x100, SrcB=0xFFFFFFFC, ex_store_data=0x55.
- Load-use hazard:
  - EX holds a load with rd=8; ID has rs2=8 and id_valid=1: load_use_hazard=1 in the same cycle.
  - Next edge: ex_valid=0 and ex_reg_write=0.
  - Following cycle, with the ID instruction held: hazard=0 and the instruction is captured.
- Stall and flush precedence:
  - stall=1 for 3 cycles while ID changes: EX outputs are unchanged.
  - stall=1 and flush=1 together: next edge gives a bubble (ex_valid=0, Operation=0).
- Asynchronous reset mid-operation:
  - Assert reset between edges while ex_valid=1 and a hazard is active.
  - Outputs clear before the next edge, and load_use_hazard=0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, PC/immediate operand select,
// store-data forwarding and a combinational load-use stall request.
module ex_operand_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4,
    parameter int unsigned REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [REG_ADDR_W-1:0]    id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]    id_rs2_addr,
    input  logic [REG_ADDR_W-1:0]    id_rd_addr,
    input  logic                     id_alu_src_a,
    input  logic                     id_alu_src_b,
    input  logic [OPCODE_LENGTH-1:0] id_operation,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic [REG_ADDR_W-1:0]    mem_rd_addr,
    input  logic                     mem_reg_write,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic [REG_ADDR_W-1:0]    wb_rd_addr,
    input  logic                     wb_reg_write,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ex_valid,
    output logic [REG_ADDR_W-1:0]    ex_rd_addr,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     load_use_hazard
);

    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    pc_q, pc_d;
    logic [DATA_WIDTH-1:0]    rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0]    rs2_data_q, rs2_data_d;
    logic [DATA_WIDTH-1:0]    imm_q, imm_d;
    logic [REG_ADDR_W-1:0]    rs1_addr_q, rs1_addr_d;
    logic [REG_ADDR_W-1:0]    rs2_addr_q, rs2_addr_d;
    logic [REG_ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                     alu_src_a_q, alu_src_a_d;
    logic                     alu_src_b_q, alu_src_b_d;
    logic [OPCODE_LENGTH-1:0] operation_q, operation_d;
    logic                     reg_write_q, reg_write_d;
    logic                     mem_read_q, mem_read_d;

    logic [DATA_WIDTH-1:0]    fwd_a, fwd_b;
    logic                     bubble;

    always_comb begin
        load_use_hazard = valid_q & mem_read_q & (rd_addr_q != '0) & id_valid &
                          ((rd_addr_q == id_rs1_addr) | (rd_addr_q == id_rs2_addr));
    end

    assign bubble = flush | (~stall & load_use_hazard);

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        alu_src_a_d = alu_src_a_q;
        alu_src_b_d = alu_src_b_q;
        operation_d = operation_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        if (bubble) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            rs1_addr_d  = '0;
            rs2_addr_d  = '0;
            rd_addr_d   = '0;
            alu_src_a_d = 1'b0;
            alu_src_b_d = 1'b0;
            operation_d = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (!stall) begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rd_addr_d   = id_rd_addr;
            alu_src_a_d = id_alu_src_a;
            alu_src_b_d = id_alu_src_b;
            operation_d = id_operation;
            reg_write_d = id_reg_write & id_valid;
            mem_read_d  = id_mem_read & id_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            alu_src_a_q <= 1'b0;
            alu_src_b_q <= 1'b0;
            operation_q <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            alu_src_a_q <= alu_src_a_d;
            alu_src_b_q <= alu_src_b_d;
            operation_q <= operation_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
    always_comb begin
        fwd_a = rs1_data_q;
        if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == rs1_addr_q) begin
            fwd_a = mem_result;
        end else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == rs1_addr_q) begin
            fwd_a = wb_result;
        end
    end

    always_comb begin
        fwd_b = rs2_data_q;
        if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == rs2_addr_q) begin
            fwd_b = mem_result;
        end else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == rs2_addr_q) begin
            fwd_b = wb_result;
        end
    end

    assign SrcA          = alu_src_a_q ? pc_q : fwd_a;
    assign SrcB          = alu_src_b_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign Operation     = operation_q;
    assign ex_valid      = valid_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_write  = reg_write_q & valid_q;
    assign ex_mem_read   = mem_read_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed plus randomized checks of ex_operand_stage against an instruction-level model.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_alu_src_a, id_alu_src_b;
    logic [3:0]  id_operation;
    logic        id_reg_write, id_mem_read;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write, ex_mem_read, load_use_hazard;
    logic [4:0]  ex_rd_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
        .id_operation(id_operation), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
    );

    // The instruction currently sitting in EX, as the model sees it.
    typedef struct {
        bit        valid;
        bit [31:0] pc, a, b, imm;
        bit [4:0]  rs1, rs2, rd;
        bit        sa, sb, rw, mr;
        bit [3:0]  op;
    } instr_t;

    instr_t m;

    function automatic instr_t bubble_instr();
        instr_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic bit model_hazard();
        return m.valid && m.mr && m.rd != 0 && id_valid &&
               (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
    endfunction

    function automatic bit [31:0] forward(bit [4:0] idx, bit [31:0] regval);
        if (idx == 0) return regval;
        if (mem_reg_write && mem_rd_addr == idx) return mem_result;
        if (wb_reg_write && wb_rd_addr == idx) return wb_result;
        return regval;
    endfunction

    function automatic instr_t model_next();
        instr_t t;
        if (flush) return bubble_instr();
        if (stall) return m;
        if (model_hazard()) return bubble_instr();
        t.valid = id_valid;      t.pc  = id_pc;        t.a   = id_rs1_data;
        t.b     = id_rs2_data;   t.imm = id_imm;       t.rs1 = id_rs1_addr;
        t.rs2   = id_rs2_addr;   t.rd  = id_rd_addr;   t.sa  = id_alu_src_a;
        t.sb    = id_alu_src_b;  t.op  = id_operation;
        t.rw    = id_reg_write && id_valid;
        t.mr    = id_mem_read && id_valid;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        bit [31:0] fa, fb;
        fa = forward(m.rs1, m.a);
        fb = forward(m.rs2, m.b);
        chk({tag, ".SrcA"}, SrcA, m.sa ? m.pc : fa);
        chk({tag, ".SrcB"}, SrcB, m.sb ? m.imm : fb);
        chk({tag, ".store"}, ex_store_data, fb);
        chk({tag, ".op"}, {28'd0, Operation}, {28'd0, m.op});
        chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
        chk({tag, ".rd"}, {27'd0, ex_rd_addr}, {27'd0, m.rd});
        chk({tag, ".rw"}, {31'd0, ex_reg_write}, {31'd0, m.rw});
        chk({tag, ".mr"}, {31'd0, ex_mem_read}, {31'd0, m.mr});
        chk({tag, ".hz"}, {31'd0, load_use_hazard}, {31'd0, model_hazard()});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_imm = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_src_a = 0;
        id_alu_src_b = 0; id_operation = 0; id_reg_write = 0; id_mem_read = 0;
        mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    task automatic randomize_inputs();
        stall = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 9) == 0);
        id_valid = ($urandom_range(0, 4) != 0);
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
        id_rd_addr = 5'($urandom_range(0, 7));
        id_alu_src_a = 1'($urandom); id_alu_src_b = 1'($urandom);
        id_operation = 4'($urandom); id_reg_write = 1'($urandom);
        id_mem_read = ($urandom_range(0, 2) == 0);
        mem_rd_addr = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom);
        mem_result = $urandom;
        wb_rd_addr = 5'($urandom_range(0, 7)); wb_reg_write = 1'($urandom);
        wb_result = $urandom;
    endtask

    initial begin
        instr_t nxt;
        clear_inputs();
        reset = 1;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", {31'd0, ex_valid}, 32'd0);
        chk("rst.op", {28'd0, Operation}, 32'd0);
        chk("rst.rd", {27'd0, ex_rd_addr}, 32'd0);
        chk("rst.rw", {31'd0, ex_reg_write}, 32'd0);
        chk("rst.mr", {31'd0, ex_mem_read}, 32'd0);
        chk("rst.SrcA", SrcA, 32'd0);
        chk("rst.SrcB", SrcB, 32'd0);
        chk("rst.store", ex_store_data, 32'd0);
        chk("rst.hz", {31'd0, load_use_hazard}, 32'd0);
        reset = 0;

        // Basic capture
        id_valid = 1; id_rs1_data = 5; id_rs2_data = 7; id_operation = 4'b0010;
        id_rd_addr = 3; id_rs1_addr = 1; id_rs2_addr = 2;
        step();
        chk("cap.SrcA", SrcA, 32'd5);
        chk("cap.SrcB", SrcB, 32'd7);
        chk("cap.op", {28'd0, Operation}, 32'd2);
        chk("cap.rd", {27'd0, ex_rd_addr}, 32'd3);
        chk("cap.valid", {31'd0, ex_valid}, 32'd1);

        // MEM over WB forwarding priority
        id_rs1_addr = 4; id_rs1_data = 32'h99;
        step();
        mem_reg_write = 1; mem_rd_addr = 4; mem_result = 32'h11;
        wb_reg_write = 1; wb_rd_addr = 4; wb_result = 32'h22;
        #1 chk("fwd.mem", SrcA, 32'h11);
        mem_reg_write = 0;
        #1 chk("fwd.wb", SrcA, 32'h22);
        wb_reg_write = 0;
        #1 chk("fwd.none", SrcA, 32'h99);
        mem_reg_write = 1; mem_rd_addr = 0; id_rs1_addr = 0; id_rs1_data = 0;
        step();
        chk("fwd.x0", SrcA, 32'd0);

        // PC/immediate select and store data forwarding
        id_alu_src_a = 1; id_pc = 32'h100; id_alu_src_b = 1; id_imm = 32'hFFFF_FFFC;
        id_rs2_addr = 6; id_rs2_data = 32'h77;
        step();
        mem_reg_write = 1; mem_rd_addr = 6; mem_result = 32'h55;
        #1;
        chk("sel.SrcA", SrcA, 32'h100);
        chk("sel.SrcB", SrcB, 32'hFFFF_FFFC);
        chk("sel.store", ex_store_data, 32'h55);
        mem_reg_write = 0;
        #1 chk("sel.store_nofwd", ex_store_data, 32'h77);

        // Load-use hazard
        id_alu_src_a = 0; id_alu_src_b = 0;
        id_mem_read = 1; id_reg_write = 1; id_rd_addr = 8; id_rs1_addr = 1; id_rs2_addr = 2;
        step();
        chk("lu.mr", {31'd0, ex_mem_read}, 32'd1);
        id_mem_read = 0; id_rs2_addr = 8; id_rd_addr = 9; id_rs2_data = 32'h1234;
        id_operation = 4'b0110;
        #1 chk("lu.hz", {31'd0, load_use_hazard}, 32'd1);
        step();
        chk("lu.bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu.bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("lu.hz_drop", {31'd0, load_use_hazard}, 32'd0);
        step();
        chk("lu.cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu.cap_rd", {27'd0, ex_rd_addr}, 32'd9);
        chk("lu.cap_SrcB", SrcB, 32'h1234);

        // Stall holds EX while ID changes
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_rd_addr = 5'(10 + i); id_operation = 4'(i); id_rs2_data = $urandom;
            step();
            chk("stall.rd", {27'd0, ex_rd_addr}, 32'd9);
            chk("stall.op", {28'd0, Operation}, 32'd6);
            chk("stall.SrcB", SrcB, 32'h1234);
        end
        flush = 1;
        step();
        chk("sf.valid", {31'd0, ex_valid}, 32'd0);
        chk("sf.op", {28'd0, Operation}, 32'd0);
        stall = 0; flush = 0;

        // Asynchronous reset while a hazard is pending
        id_valid = 1; id_mem_read = 1; id_rd_addr = 8; id_rs1_addr = 1; id_rs2_addr = 2;
        id_operation = 4'b0011; id_rs1_data = 32'hABCD;
        step();
        id_mem_read = 0; id_rs1_addr = 8;
        #1 chk("ar.hz_before", {31'd0, load_use_hazard}, 32'd1);
        #1 reset = 1;
        #1;
        chk("ar.valid", {31'd0, ex_valid}, 32'd0);
        chk("ar.hz", {31'd0, load_use_hazard}, 32'd0);
        chk("ar.op", {28'd0, Operation}, 32'd0);
        chk("ar.SrcA", SrcA, 32'd0);
        #1 reset = 0;
        m = bubble_instr();

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            #1 check_model("rnd.pre");
            nxt = model_next();
            @(posedge clk);
            m = nxt;
            #1 check_model("rnd.post");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
